// File: rtl/imem_loader.sv
// Instruction memory loader: framed byte stream -> 16-bit word writes, holds CPU in reset while busy.
// Latency: write strobe one cycle after the high-byte accept; optional trailing XOR check (IMEM_LOADER_CHECKSUM_EN).
// Backpressure: in_ready is purely state-based; in_valid low stalls any state indefinitely.
module imem_loader #(
    parameter int MAX_WORDS = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [8:0]        words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LO  = 3'd1,
        S_LEN_HI  = 3'd2,
        S_DATA_LO = 3'd3,
        S_DATA_HI = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK   = 3'd5,
`endif
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        start_load;
    logic        len_bad;
    logic        last_word;
    logic [15:0] len_full;
    logic [7:0]  len_lo_q;
    logic [8:0]  len_q;
    logic [7:0]  lo_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign accept     = in_valid && in_ready;
    assign len_full   = {in_data, len_lo_q};
    assign len_bad    = (len_full == 16'd0) || (len_full > 16'(MAX_WORDS));
    assign last_word  = (words_loaded + 9'd1) == len_q;
    assign start_load = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

    // Every byte-consuming state is a busy state, so the two flags coincide.
    assign busy     = in_ready;
    assign cpu_hold = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (accept) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (accept) state_nxt = len_bad ? S_ERROR : S_DATA_LO;
            end
            S_DATA_LO: begin
                in_ready = 1'b1;
                if (accept) state_nxt = S_DATA_HI;
            end
            S_DATA_HI: begin
                in_ready = 1'b1;
                if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = last_word ? S_CHECK : S_DATA_LO;
`else
                    state_nxt = last_word ? S_DONE : S_DATA_LO;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                in_ready = 1'b1;
                if (accept) state_nxt = (in_data == csum_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            words_loaded <= '0;
            len_lo_q     <= '0;
            len_q        <= '0;
            lo_q         <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            // Flags follow the next state, so they clear on restart and stay sticky otherwise.
            done  <= (state_nxt == S_DONE);
            error <= (state_nxt == S_ERROR);
            if (start_load) begin
                words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_q       <= '0;
`endif
            end
            if (accept) begin
                case (state)
                    S_LEN_LO: len_lo_q <= in_data;
                    S_LEN_HI: len_q    <= len_full[8:0];
                    S_DATA_LO: begin
                        lo_q <= in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ in_data;
`endif
                    end
                    S_DATA_HI: begin
                        wr_en        <= 1'b1;
                        wr_addr      <= words_loaded[ADDR_W-1:0];
                        wr_data      <= {in_data, lo_q};
                        words_loaded <= words_loaded + 9'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q       <= csum_q ^ in_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
